// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control bundle bit positions, debug FSM encoding, bubble value.
package cpu_pkg;

  localparam int CTRL_W_DEF = 20;
  localparam int LU_CNT_W   = 2;

  // Bit positions inside the packed control bundle; ALU_OP occupies [11:8].
  typedef enum int {
    REG_DST    = 0,
    ALU_SRC    = 1,
    MEM_TO_REG = 2,
    REG_WRITE  = 3,
    MEM_READ   = 4,
    MEM_WRITE  = 5,
    BRANCH     = 6,
    JUMP       = 7,
    ALU_OP_LSB = 8,
    ALU_OP_MSB = 11,
    LINK       = 12,
    SIGN_EXT   = 13
  } ctrl_bit_e;

  typedef enum logic [1:0] {
    DBG_RUN  = 2'd0,
    DBG_HALT = 2'd1,
    DBG_STEP = 2'd2
  } dbg_state_e;

  localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_bp_match.sv
// Breakpoint slot file with per-slot PC comparators and a lowest-index-wins priority encoder.
module id_bp_match
  import cpu_pkg::*;
#(
  parameter int  NUM_BP = 4,
  parameter int  ADDR_W = 32,
  localparam int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] match_pc,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx
);

  logic [ADDR_W-1:0] bp_addr_q [NUM_BP];
  logic [ADDR_W-1:0] bp_addr_d [NUM_BP];
  logic [NUM_BP-1:0] bp_valid_q, bp_valid_d;

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    bp_addr_d  = bp_addr_q;
    bp_valid_d = bp_valid_q;
    for (int i = 0; i < NUM_BP; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        bp_addr_d[i]  = wr_addr;
        bp_valid_d[i] = wr_valid;
      end
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the slot array is reset explicitly; stale valid bits would trigger spurious halts.
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
      bp_valid_q <= '0;
    end else begin
      bp_addr_q  <= bp_addr_d;
      bp_valid_q <= bp_valid_d;
    end
  end

  // Scan downwards so the lowest matching slot is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_valid_q[i] && (bp_addr_q[i] == match_pc)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/id_stage_dbg.sv
// ID->EX pipeline register with load-use hazard bubbles and a breakpoint debug FSM.
// Optional single-step support is enabled by defining ID_SINGLE_STEP_EN.
module id_stage_dbg
  import cpu_pkg::*;
#(
  parameter int  NUM_BP          = 4,
  parameter int  ADDR_W          = 32,
  parameter int  CTRL_W          = 20,
  parameter int  LOAD_USE_CYCLES = 1,
  localparam int IDX_W           = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       if_id_instruction,
  input  logic [ADDR_W-1:0] if_id_pc_next,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              flush_id,
  input  logic              continue_sig,
  input  logic              step_sig,
  input  logic              bp_wr_en,
  input  logic [IDX_W-1:0]  bp_wr_idx,
  input  logic [ADDR_W-1:0] bp_wr_addr,
  input  logic              bp_wr_valid,
  output logic [4:0]        id_ex_rs,
  output logic [4:0]        id_ex_rt,
  output logic [4:0]        id_ex_rd,
  output logic [4:0]        id_ex_shamt,
  output logic [31:0]       id_ex_imm,
  output logic [ADDR_W-1:0] id_ex_pc_next,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              stall,
  output logic              halted,
  output logic [IDX_W-1:0]  bp_hit_idx
);

  logic [4:0]          rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
  logic [31:0]         imm_q, imm_d;
  logic [ADDR_W-1:0]   pc_next_q, pc_next_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  dbg_state_e          state_q, state_d;
  logic                resume_q, resume_d;
  logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
  logic                cont_prev_q, cont_prev_d;

  logic [4:0]       if_rs, if_rt;
  logic [5:0]       unused_opcode;
  logic             bp_hit, detect, load_use, halt_cond, advance, cont_edge;
  logic [IDX_W-1:0] bp_idx;

  assign if_rs         = if_id_instruction[25:21];
  assign if_rt         = if_id_instruction[20:16];
  assign unused_opcode = if_id_instruction[31:26];

`ifdef ID_SINGLE_STEP_EN
  logic step_prev_q, step_prev_d, step_edge;
  assign step_prev_d = step_sig;
  assign step_edge   = step_sig && !step_prev_q;
`else
  logic unused_step;
  assign unused_step = step_sig;
`endif

  // Breakpoints are set on the instruction address, ID only carries PC+4.
  id_bp_match #(.NUM_BP(NUM_BP), .ADDR_W(ADDR_W)) u_bp_match (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bp_wr_en),
    .wr_idx   (bp_wr_idx),
    .wr_addr  (bp_wr_addr),
    .wr_valid (bp_wr_valid),
    .match_pc (if_id_pc_next - ADDR_W'(4)),
    .hit      (bp_hit),
    .hit_idx  (bp_idx)
  );

  always_comb begin
    cont_prev_d = continue_sig;
    cont_edge   = continue_sig && !cont_prev_q;
    detect      = ctrl_q[MEM_TO_REG] && (rt_q != 5'd0) && ((rt_q == if_rs) || (rt_q == if_rt));
    load_use    = detect || (lu_cnt_q != '0);

    // Hazard counter keeps running through a flush but is never loaded by one.
    lu_cnt_d = (lu_cnt_q != '0) ? lu_cnt_q - LU_CNT_W'(1) : '0;
    if (!flush_id && detect) lu_cnt_d = LU_CNT_W'(LOAD_USE_CYCLES - 1);

    state_d   = state_q;
    resume_d  = resume_q;
    hit_idx_d = hit_idx_q;
    halt_cond = 1'b0;
    case (state_q)
      DBG_RUN: begin
        if (bp_hit && !resume_q && !flush_id && !load_use) begin
          state_d   = DBG_HALT;
          hit_idx_d = bp_idx;
          halt_cond = 1'b1;
        end
      end
      DBG_HALT: begin
        halt_cond = 1'b1;
        if (cont_edge) begin
          state_d  = DBG_RUN;
          resume_d = 1'b1;
        end
`ifdef ID_SINGLE_STEP_EN
        else if (step_edge) begin
          state_d = DBG_STEP;
        end
`endif
      end
`ifdef ID_SINGLE_STEP_EN
      DBG_STEP: begin
        if (!flush_id && !load_use) state_d = DBG_HALT;
      end
`endif
      default: state_d = DBG_RUN;
    endcase

    advance = !flush_id && !load_use && !halt_cond;
    if (advance) resume_d = 1'b0;

    rs_d      = '0;
    rt_d      = '0;
    rd_d      = '0;
    shamt_d   = '0;
    imm_d     = '0;
    pc_next_d = '0;
    ctrl_d    = CTRL_W'(BUBBLE_CTRL);
    if (advance) begin
      rs_d      = if_rs;
      rt_d      = if_rt;
      rd_d      = if_id_instruction[15:11];
      shamt_d   = if_id_instruction[10:6];
      imm_d     = {{16{if_id_instruction[15]}}, if_id_instruction[15:0]};
      pc_next_d = if_id_pc_next;
      ctrl_d    = ctrl_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      shamt_q     <= '0;
      imm_q       <= '0;
      pc_next_q   <= '0;
      ctrl_q      <= '0;
      lu_cnt_q    <= '0;
      state_q     <= DBG_RUN;
      resume_q    <= 1'b0;
      hit_idx_q   <= '0;
      cont_prev_q <= 1'b0;
`ifdef ID_SINGLE_STEP_EN
      step_prev_q <= 1'b0;
`endif
    end else begin
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      shamt_q     <= shamt_d;
      imm_q       <= imm_d;
      pc_next_q   <= pc_next_d;
      ctrl_q      <= ctrl_d;
      lu_cnt_q    <= lu_cnt_d;
      state_q     <= state_d;
      resume_q    <= resume_d;
      hit_idx_q   <= hit_idx_d;
      cont_prev_q <= cont_prev_d;
`ifdef ID_SINGLE_STEP_EN
      step_prev_q <= step_prev_d;
`endif
    end
  end

  assign id_ex_rs      = rs_q;
  assign id_ex_rt      = rt_q;
  assign id_ex_rd      = rd_q;
  assign id_ex_shamt   = shamt_q;
  assign id_ex_imm     = imm_q;
  assign id_ex_pc_next = pc_next_q;
  assign id_ex_ctrl    = ctrl_q;
  assign stall         = load_use || halt_cond;
  assign halted        = (state_q == DBG_HALT);
  assign bp_hit_idx    = hit_idx_q;

endmodule

// File: tb/tb_id_stage_dbg.sv
// Directed bench for id_stage_dbg: u_a uses one load-use bubble, u_b uses three; both share stimulus.
module tb_id_stage_dbg;

  localparam int ADDR_W = 32;
  localparam int CTRL_W = 20;
  localparam int IDX_W  = 2;
  localparam logic [CTRL_W-1:0] C_LW  = 20'h0001E;  // ALU_SRC|MEM_TO_REG|REG_WRITE|MEM_READ
  localparam logic [CTRL_W-1:0] C_ADD = 20'h00009;  // REG_DST|REG_WRITE

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc_next;
  logic [CTRL_W-1:0] ctrl_in;
  logic              flush_id, continue_sig, step_sig, bp_wr_en, bp_wr_valid;
  logic [IDX_W-1:0]  bp_wr_idx;
  logic [ADDR_W-1:0] bp_wr_addr;

  logic [4:0]        rs_a, rt_a, rd_a, shamt_a, rs_b, rt_b, rd_b, shamt_b;
  logic [31:0]       imm_a, imm_b;
  logic [ADDR_W-1:0] pcn_a, pcn_b;
  logic [CTRL_W-1:0] ctrl_a, ctrl_b;
  logic              stall_a, halted_a, stall_b, halted_b;
  logic [IDX_W-1:0]  hit_a, hit_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage_dbg #(.NUM_BP(4), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .LOAD_USE_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .if_id_instruction(instr), .if_id_pc_next(pc_next),
    .ctrl_in(ctrl_in), .flush_id(flush_id), .continue_sig(continue_sig), .step_sig(step_sig),
    .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid),
    .id_ex_rs(rs_a), .id_ex_rt(rt_a), .id_ex_rd(rd_a), .id_ex_shamt(shamt_a), .id_ex_imm(imm_a),
    .id_ex_pc_next(pcn_a), .id_ex_ctrl(ctrl_a), .stall(stall_a), .halted(halted_a), .bp_hit_idx(hit_a)
  );

  id_stage_dbg #(.NUM_BP(4), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .LOAD_USE_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .if_id_instruction(instr), .if_id_pc_next(pc_next),
    .ctrl_in(ctrl_in), .flush_id(flush_id), .continue_sig(continue_sig), .step_sig(step_sig),
    .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid),
    .id_ex_rs(rs_b), .id_ex_rt(rt_b), .id_ex_rd(rd_b), .id_ex_shamt(shamt_b), .id_ex_imm(imm_b),
    .id_ex_pc_next(pcn_b), .id_ex_ctrl(ctrl_b), .stall(stall_b), .halted(halted_b), .bp_hit_idx(hit_b)
  );

  function automatic logic [31:0] enc_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, 6'h20};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [ADDR_W-1:0] p, input logic [CTRL_W-1:0] c);
    instr   = i;
    pc_next = p;
    ctrl_in = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    drive(enc_add(5'd1, 5'd2, 5'd3, 5'd4), 32'h40, C_ADD);
    flush_id = 0; continue_sig = 0; step_sig = 0;
    bp_wr_en = 0; bp_wr_idx = '0; bp_wr_addr = '0; bp_wr_valid = 0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_ctrl", 32'(ctrl_a), 0);
    check("rst_pcn", pcn_a, 0);
    check("rst_rd", 32'(rd_a), 0);
    check("rst_halted", 32'(halted_a), 0);
    check("rst_hit_idx", 32'(hit_a), 0);
    check("rst_stall", 32'(stall_a), 0);
    rst_n = 1'b1;

    // lw $t0,-4($t2) advances with sign-extended immediate
    drive(enc_lw(5'd10, 5'd8, 16'hFFFC), 32'h104, C_LW);
    #1 check("lw_stall", 32'(stall_a), 0);
    tick();
    check("lw_rs", 32'(rs_a), 10);
    check("lw_rt", 32'(rt_a), 8);
    check("lw_imm", imm_a, 32'hFFFF_FFFC);
    check("lw_pcn", pcn_a, 32'h104);
    check("lw_ctrl", 32'(ctrl_a), 32'(C_LW));

    // add $t1,$t0,$t2 depends on the load: one bubble then issue
    drive(enc_add(5'd8, 5'd10, 5'd9, 5'd0), 32'h108, C_ADD);
    #1 check("lu_stall", 32'(stall_a), 1);
    tick();
    check("lu_bubble_ctrl", 32'(ctrl_a), 0);
    check("lu_bubble_rd", 32'(rd_a), 0);
    #1 check("lu_stall_clr", 32'(stall_a), 0);
    tick();
    check("lu_add_rd", 32'(rd_a), 9);
    check("lu_add_ctrl", 32'(ctrl_a), 32'(C_ADD));

    // load into $zero never stalls
    drive(enc_lw(5'd10, 5'd0, 16'h0008), 32'h10C, C_LW);
    tick();
    drive(enc_add(5'd0, 5'd0, 5'd11, 5'd3), 32'h110, C_ADD);
    #1 check("zero_stall", 32'(stall_a), 0);
    tick();
    check("zero_rd", 32'(rd_a), 11);
    check("zero_shamt", 32'(shamt_a), 3);

    // three-bubble instance, dependency through rt
    do_reset();
    drive(enc_lw(5'd10, 5'd8, 16'h0000), 32'h200, C_LW);
    tick();
    drive(enc_add(5'd10, 5'd8, 5'd12, 5'd0), 32'h204, C_ADD);
    for (int k = 0; k < 3; k++) begin
      #1 check("lu3_stall", 32'(stall_b), 1);
      tick();
      check("lu3_bubble", 32'(ctrl_b), 0);
    end
    #1 check("lu3_stall_clr", 32'(stall_b), 0);
    tick();
    check("lu3_add_rd", 32'(rd_b), 12);

    // flush wins over load-use and does not load the counter
    drive(enc_lw(5'd10, 5'd8, 16'h0000), 32'h300, C_LW);
    tick();
    drive(enc_add(5'd8, 5'd8, 5'd13, 5'd0), 32'h304, C_ADD);
    flush_id = 1;
    tick();
    check("fl_bubble", 32'(ctrl_b), 0);
    flush_id = 0;
    drive(enc_add(5'd1, 5'd2, 5'd14, 5'd0), 32'h400, C_ADD);
    #1 check("fl_no_stall", 32'(stall_b), 0);
    tick();
    check("fl_target_rd", 32'(rd_b), 14);

    // breakpoints: slot2=48 and slot0=48, lowest index reported
    do_reset();
    drive(enc_add(5'd1, 5'd2, 5'd3, 5'd0), 32'h20, C_ADD);
    bp_wr_en = 1; bp_wr_idx = 2'd2; bp_wr_addr = 32'd48; bp_wr_valid = 1;
    tick();
    bp_wr_idx = 2'd0;
    tick();
    bp_wr_en = 0;
    drive(enc_add(5'd1, 5'd2, 5'd3, 5'd0), 32'd52, C_ADD);
    #1 check("bp_stall", 32'(stall_a), 1);
    tick();
    check("bp_halted", 32'(halted_a), 1);
    check("bp_idx", 32'(hit_a), 0);
    check("bp_ctrl", 32'(ctrl_a), 0);

    // invalidating slot0 while halted keeps the halt
    bp_wr_en = 1; bp_wr_idx = 2'd0; bp_wr_valid = 0;
    tick();
    bp_wr_en = 0;
    check("bp_wr_hold", 32'(halted_a), 1);
    check("bp_hold_ctrl", 32'(ctrl_a), 0);

    // continue: instruction at 48 issues exactly once
    continue_sig = 1;
    #1 check("cont_stall", 32'(stall_a), 1);
    tick();
    check("cont_run", 32'(halted_a), 0);
    check("cont_bubble", 32'(ctrl_a), 0);
    #1 check("resume_stall", 32'(stall_a), 0);
    tick();
    check("resume_pcn", pcn_a, 52);
    check("resume_ctrl", 32'(ctrl_a), 32'(C_ADD));
    drive(enc_add(5'd4, 5'd5, 5'd6, 5'd0), 32'd56, C_ADD);
    tick();
    check("next_pcn", pcn_a, 56);

    // loop back to 48: re-hit, slot2 now the only match
    drive(enc_add(5'd1, 5'd2, 5'd3, 5'd0), 32'd52, C_ADD);
    #1 check("rehit_stall", 32'(stall_a), 1);
    tick();
    check("rehit_halted", 32'(halted_a), 1);
    check("rehit_idx", 32'(hit_a), 2);
    tick();
    check("cont_level_no_edge", 32'(halted_a), 1);

`ifdef ID_SINGLE_STEP_EN
    step_sig = 1;
    tick();
    check("step_leave_halt", 32'(halted_a), 0);
    check("step_bubble", 32'(ctrl_a), 0);
    #1 check("step_no_stall", 32'(stall_a), 0);
    tick();
    check("step_pcn", pcn_a, 52);
    check("step_rehalt", 32'(halted_a), 1);
    drive(enc_add(5'd4, 5'd5, 5'd6, 5'd0), 32'd56, C_ADD);
    #1 check("step_hold52", 32'(stall_a), 1);
    tick();
    check("step_bubble2", 32'(ctrl_a), 0);
    check("step_idx", 32'(hit_a), 2);
`else
    step_sig = 1;
    tick();
    check("step_ignored", 32'(halted_a), 1);
    check("step_ignored_ctrl", 32'(ctrl_a), 0);
`endif

    // reset while halted returns to RUN with empty register
    step_sig = 0;
    continue_sig = 0;
    do_reset();
    check("rst_halt_halted", 32'(halted_a), 0);
    check("rst_halt_ctrl", 32'(ctrl_a), 0);
    check("rst_halt_idx", 32'(hit_a), 0);
    check("rst_halt_pcn", pcn_a, 0);
    #1 check("rst_halt_stall", 32'(stall_a), 0);

    // PC+4 wraps: breakpoint at 0xFFFFFFFC matches pc_next 0
    bp_wr_en = 1; bp_wr_idx = 2'd3; bp_wr_addr = 32'hFFFF_FFFC; bp_wr_valid = 1;
    tick();
    bp_wr_en = 0;
    drive(enc_add(5'd1, 5'd2, 5'd3, 5'd0), 32'h0, C_ADD);
    #1 check("wrap_stall", 32'(stall_a), 1);
    tick();
    check("wrap_halted", 32'(halted_a), 1);
    check("wrap_idx", 32'(hit_a), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
